// File: rtl/crt_timing_gen_pkg.sv
// Shared types, default geometry and helpers for the CRT raster timing generator.
package crt_timing_gen_pkg;
`include "crt_defs.vh"

  typedef enum logic {
    SYNC_POL_LOW  = `SYNC_ACTIVE_LOW,
    SYNC_POL_HIGH = `SYNC_ACTIVE_HIGH
  } sync_pol_e;

  localparam int DEF_H_FP     = `CRT_H_FP;
  localparam int DEF_H_SYNC   = `CRT_H_SYNC;
  localparam int DEF_H_BP     = `CRT_H_BP;
  localparam int DEF_V_FP     = `CRT_V_FP;
  localparam int DEF_V_SYNC   = `CRT_V_SYNC;
  localparam int DEF_V_BP     = `CRT_V_BP;
  localparam bit DEF_SYNC_POL = SYNC_POL_LOW;

  // Drive the pin level for a sync region given the configured polarity.
  function automatic logic sync_level(input logic active, input logic pol);
    return active ? pol : ~pol;
  endfunction

endpackage

// File: rtl/crt_axis_counter.sv
// One raster axis (horizontal or vertical): position counter with active/porch/sync
// region decode. Wraps after active+fp+sync+bp advances.
module crt_axis_counter
  import crt_timing_gen_pkg::*;
#(
  parameter int CW = 12
) (
  input  logic          clock,
  input  logic          reset,
  input  logic          advance,
  input  logic [CW-1:0] active,
  input  logic [CW-1:0] fp,
  input  logic [CW-1:0] sync,
  input  logic [CW-1:0] bp,
  output logic [CW-1:0] count,
  output logic          wrap,
  output logic          in_active,
  output logic          in_sync
);

  logic [CW-1:0] sync_lo;
  logic [CW-1:0] sync_hi;
  logic [CW-1:0] total_m1;

  assign sync_lo   = active + fp;
  assign sync_hi   = sync_lo + sync;
  assign total_m1  = sync_hi + bp - CW'(1);

  assign wrap      = advance && (count == total_m1);
  assign in_active = count < active;
  assign in_sync   = (count >= sync_lo) && (count < sync_hi);

  always_ff @(posedge clock) begin
    if (!reset) begin
      count <= '0;
    end else if (wrap) begin
      count <= '0;
    end else if (advance) begin
      count <= count + CW'(1);
    end
  end

endmodule

// File: rtl/crt_defs.vh
// Default 640x480 raster timing constants and sync polarity codes, shared by the
// timing generator, the renderer and the bench.
`ifndef CRT_DEFS_VH
`define CRT_DEFS_VH

`define SYNC_ACTIVE_LOW   1'b0
`define SYNC_ACTIVE_HIGH  1'b1

`define CRT_H_ACTIVE      640
`define CRT_H_FP          16
`define CRT_H_SYNC        96
`define CRT_H_BP          48

`define CRT_V_ACTIVE      480
`define CRT_V_FP          10
`define CRT_V_SYNC        2
`define CRT_V_BP          33

`endif

// File: rtl/crt_timing_gen.sv
// Parametrised CRT/VGA raster timing generator with frame-boundary shadowed geometry
// and pixel-clock divider. Optional frame counter: define CRT_FRAME_COUNT_EN.
module crt_timing_gen
  import crt_timing_gen_pkg::*;
#(
  parameter int W        = 10,
  parameter int H_FP     = DEF_H_FP,
  parameter int H_SYNC   = DEF_H_SYNC,
  parameter int H_BP     = DEF_H_BP,
  parameter int V_FP     = DEF_V_FP,
  parameter int V_SYNC   = DEF_V_SYNC,
  parameter int V_BP     = DEF_V_BP,
  parameter bit SYNC_POL = DEF_SYNC_POL,
  parameter int DIV_W    = 4
`ifdef CRT_FRAME_COUNT_EN
  ,
  parameter int FC_W     = 8
`endif
) (
  input  logic             clock,
  input  logic             reset,
  input  logic [W-1:0]     xres,
  input  logic [W-1:0]     yres,
  input  logic [DIV_W-1:0] clk_div,
  output logic             pixel_ce,
  output logic             hsync,
  output logic             vsync,
  output logic             de,
  output logic [W-1:0]     xposition,
  output logic [W-1:0]     yposition,
  output logic             line_start,
  output logic             frame_start
`ifdef CRT_FRAME_COUNT_EN
  ,
  output logic [FC_W-1:0]  frame_count
`endif
);

  localparam int CW = W + 2;

  function automatic logic [W-1:0] clamp_min1(input logic [W-1:0] v);
    return (v == '0) ? W'(1) : v;
  endfunction

  logic [W-1:0]     xres_s;
  logic [W-1:0]     yres_s;
  logic [DIV_W-1:0] div_s;
  logic [CW-1:0]    div_cnt;
  logic [CW-1:0]    div_last;
  logic [CW-1:0]    hcnt;
  logic [CW-1:0]    vcnt;
  logic             pce_raw;
  logic             hwrap;
  logic             vwrap;
  logic             h_act;
  logic             v_act;
  logic             h_sync_act;
  logic             v_sync_act;
  logic             in_reset_p1;

  // Divide-by 0 and 1 both collapse to a pixel every system clock.
  assign div_last = CW'(div_s) - CW'(1);
  assign pce_raw  = (div_s <= DIV_W'(1)) || (div_cnt == div_last);
  assign pixel_ce = pce_raw && reset;

  crt_axis_counter #(.CW(CW)) u_hcnt (
    .clock     (clock),
    .reset     (reset),
    .advance   (pixel_ce),
    .active    (CW'(xres_s)),
    .fp        (CW'(H_FP)),
    .sync      (CW'(H_SYNC)),
    .bp        (CW'(H_BP)),
    .count     (hcnt),
    .wrap      (hwrap),
    .in_active (h_act),
    .in_sync   (h_sync_act)
  );

  crt_axis_counter #(.CW(CW)) u_vcnt (
    .clock     (clock),
    .reset     (reset),
    .advance   (hwrap),
    .active    (CW'(yres_s)),
    .fp        (CW'(V_FP)),
    .sync      (CW'(V_SYNC)),
    .bp        (CW'(V_BP)),
    .count     (vcnt),
    .wrap      (vwrap),
    .in_active (v_act),
    .in_sync   (v_sync_act)
  );

  // Counter bits above W can only be set in blanking, where position reads as zero.
  assign de        = h_act && v_act && ~|hcnt[CW-1:W] && ~|vcnt[CW-1:W];
  assign xposition = de ? hcnt[W-1:0] : '0;
  assign yposition = de ? vcnt[W-1:0] : '0;
  assign hsync     = sync_level(h_sync_act, SYNC_POL);
  assign vsync     = sync_level(v_sync_act, SYNC_POL);

  // Stage p1: divider, frame-boundary shadow load and registered strobes.
  always_ff @(posedge clock) begin
    if (!reset) begin
      div_cnt     <= '0;
      xres_s      <= clamp_min1(xres);
      yres_s      <= clamp_min1(yres);
      div_s       <= clk_div;
      line_start  <= 1'b0;
      frame_start <= 1'b0;
      in_reset_p1 <= 1'b1;
    end else begin
      div_cnt <= pixel_ce ? '0 : div_cnt + CW'(1);
      if (vwrap) begin
        xres_s <= clamp_min1(xres);
        yres_s <= clamp_min1(yres);
        div_s  <= clk_div;
      end
      line_start  <= hwrap || in_reset_p1;
      frame_start <= vwrap || in_reset_p1;
      in_reset_p1 <= 1'b0;
    end
  end

`ifdef CRT_FRAME_COUNT_EN
  // The post-reset frame_start strobe is not a wrap, so it leaves the count at zero.
  always_ff @(posedge clock) begin
    if (!reset) begin
      frame_count <= '0;
    end else if (vwrap) begin
      frame_count <= frame_count + FC_W'(1);
    end
  end
`endif

endmodule

// File: tb/tb_crt_timing_gen.sv
// Bench for crt_timing_gen: hand-derived first-frame vectors, directed corner sequences
// and randomized inputs checked against a clock-count based raster model.
module tb_crt_timing_gen;

  localparam int W      = 10;
  localparam int DIV_W  = 4;
  localparam int H_FP   = 1;
  localparam int H_SYNC = 2;
  localparam int H_BP   = 1;
  localparam int V_FP   = 1;
  localparam int V_SYNC = 1;
  localparam int V_BP   = 1;
  localparam bit POL    = 1'b0;
  localparam int FC_W   = 2;
`ifdef CRT_FRAME_COUNT_EN
  localparam bit FC_EN  = 1'b1;
`else
  localparam bit FC_EN  = 1'b0;
`endif

  typedef struct packed {
    logic         pce;
    logic         hs;
    logic         vs;
    logic         de;
    logic [W-1:0] x;
    logic [W-1:0] y;
    logic         ls;
    logic         fs;
    logic [1:0]   fc;
  } obs_t;

  typedef struct packed {
    int   k;
    obs_t exp;
  } vec_t;

  logic             clock = 1'b0;
  logic             reset = 1'b0;
  logic [W-1:0]     xres;
  logic [W-1:0]     yres;
  logic [DIV_W-1:0] clk_div;
  logic             pixel_ce, hsync, vsync, de, line_start, frame_start;
  logic [W-1:0]     xposition, yposition;
`ifdef CRT_FRAME_COUNT_EN
  logic [FC_W-1:0]  frame_count;
`endif

  int vectors = 0;
  int miscompares = 0;

  always #5 clock = ~clock;

  crt_timing_gen #(
    .W(W), .H_FP(H_FP), .H_SYNC(H_SYNC), .H_BP(H_BP),
    .V_FP(V_FP), .V_SYNC(V_SYNC), .V_BP(V_BP), .SYNC_POL(POL), .DIV_W(DIV_W)
`ifdef CRT_FRAME_COUNT_EN
    , .FC_W(FC_W)
`endif
  ) dut (
    .clock(clock), .reset(reset), .xres(xres), .yres(yres), .clk_div(clk_div),
    .pixel_ce(pixel_ce), .hsync(hsync), .vsync(vsync), .de(de),
    .xposition(xposition), .yposition(yposition),
    .line_start(line_start), .frame_start(frame_start)
`ifdef CRT_FRAME_COUNT_EN
    , .frame_count(frame_count)
`endif
  );

  // Reference model: raster position derived from clocks elapsed since frame start.
  int m_t, m_xs, m_ys, m_ds, m_fc, m_total;
  bit m_ls, m_fs, m_wasrst, m_valid = 1'b0;

  function automatic int div_of(input int ds);
    return (ds <= 1) ? 1 : ds;
  endfunction

  always @(posedge clock) begin
    if (!reset) begin
      m_t = 0; m_xs = (xres == 0) ? 1 : int'(xres); m_ys = (yres == 0) ? 1 : int'(yres);
      m_ds = int'(clk_div); m_ls = 0; m_fs = 0; m_fc = 0; m_wasrst = 1; m_valid = 1;
    end else if (m_valid) begin
      m_total = div_of(m_ds) * (m_xs + H_FP + H_SYNC + H_BP) * (m_ys + V_FP + V_SYNC + V_BP);
      m_t = m_t + 1;
      m_fs = 0;
      if (m_t == m_total) begin
        m_t = 0; m_fs = 1; m_fc = (m_fc + 1) % (1 << FC_W);
        m_xs = (xres == 0) ? 1 : int'(xres); m_ys = (yres == 0) ? 1 : int'(yres);
        m_ds = int'(clk_div);
      end
      m_ls = m_wasrst || ((m_t % div_of(m_ds) == 0) &&
             ((m_t / div_of(m_ds)) % (m_xs + H_FP + H_SYNC + H_BP) == 0));
      m_fs = m_fs || m_wasrst;
      m_wasrst = 0;
    end
  end

  function automatic int cur_h();
    return (m_t / div_of(m_ds)) % (m_xs + H_FP + H_SYNC + H_BP);
  endfunction

  function automatic int cur_v();
    return (m_t / div_of(m_ds)) / (m_xs + H_FP + H_SYNC + H_BP);
  endfunction

  function automatic obs_t model_obs();
    obs_t o;
    int d, h, v;
    d = div_of(m_ds); h = cur_h(); v = cur_v();
    o.pce = reset && (m_t % d == d - 1);
    o.hs  = (h >= m_xs + H_FP && h < m_xs + H_FP + H_SYNC) ? POL : !POL;
    o.vs  = (v >= m_ys + V_FP && v < m_ys + V_FP + V_SYNC) ? POL : !POL;
    o.de  = (h < m_xs) && (v < m_ys);
    o.x   = o.de ? W'(h) : '0;
    o.y   = o.de ? W'(v) : '0;
    o.ls  = m_ls;
    o.fs  = m_fs;
    o.fc  = FC_EN ? 2'(m_fc) : 2'b0;
    return o;
  endfunction

  function automatic obs_t dut_obs();
    obs_t o;
    o.pce = pixel_ce; o.hs = hsync; o.vs = vsync; o.de = de;
    o.x = xposition; o.y = yposition; o.ls = line_start; o.fs = frame_start;
`ifdef CRT_FRAME_COUNT_EN
    o.fc = frame_count;
`else
    o.fc = 2'b0;
`endif
    return o;
  endfunction

  function automatic obs_t mk(bit pce, bit hs, bit vs, bit d, int x, int y, bit ls, bit fs, int fc);
    obs_t o;
    o.pce = pce; o.hs = hs; o.vs = vs; o.de = d; o.x = W'(x); o.y = W'(y);
    o.ls = ls; o.fs = fs; o.fc = FC_EN ? 2'(fc) : 2'b0;
    return o;
  endfunction

  task automatic check(input string name, input obs_t act, input obs_t exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s t=%0t act{pce,hs,vs,de,x,y,ls,fs,fc}=%h exp=%h", name, $time, act, exp);
    end
  endtask

  task automatic check_int(input string name, input int act, input int exp);
    vectors++;
    if (act != exp) begin
      miscompares++;
      $display("FAIL %s t=%0t act=%0d exp=%0d", name, $time, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    @(negedge clock);
    if (m_valid) check("model", dut_obs(), model_obs());
  endtask

  task automatic wait_for(input bit want_fs, input int budget, input string name);
    int n = 0;
    while (!(want_fs ? frame_start : line_start) && n < budget) begin
      tick(); n++;
    end
    check_int(name, int'(want_fs ? frame_start : line_start), 1);
  endtask

  task automatic wait_pos(input int h, input int v, input int budget, input string name);
    int n = 0;
    while (!(cur_h() == h && cur_v() == v) && n < budget) begin
      tick(); n++;
    end
    check_int(name, int'(cur_h() == h && cur_v() == v), 1);
  endtask

  task automatic measure_line(input string name, input int exp);
    int n = 0;
    do begin tick(); n++; end while (!line_start && n < 200);
    check_int(name, n, exp);
  endtask

  vec_t tbl[15];
  obs_t rst_exp;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish act=running exp=done");
    $fatal(1, "watchdog");
  end

  initial begin
    int k, cnt, n;
    rst_exp = mk(0, 1, 1, 1, 0, 0, 0, 0, 0);
    // Hand-derived first frame for 5x4, div 2: htotal 9, vtotal 7, 126 clocks/frame.
    tbl[0]  = '{k:1,   exp:mk(1, 1, 1, 1, 0, 0, 1, 1, 0)};
    tbl[1]  = '{k:2,   exp:mk(0, 1, 1, 1, 1, 0, 0, 0, 0)};
    tbl[2]  = '{k:12,  exp:mk(0, 0, 1, 0, 0, 0, 0, 0, 0)};
    tbl[3]  = '{k:13,  exp:mk(1, 0, 1, 0, 0, 0, 0, 0, 0)};
    tbl[4]  = '{k:15,  exp:mk(1, 0, 1, 0, 0, 0, 0, 0, 0)};
    tbl[5]  = '{k:16,  exp:mk(0, 1, 1, 0, 0, 0, 0, 0, 0)};
    tbl[6]  = '{k:18,  exp:mk(0, 1, 1, 1, 0, 1, 1, 0, 0)};
    tbl[7]  = '{k:19,  exp:mk(1, 1, 1, 1, 0, 1, 0, 0, 0)};
    tbl[8]  = '{k:72,  exp:mk(0, 1, 1, 0, 0, 0, 1, 0, 0)};
    tbl[9]  = '{k:80,  exp:mk(0, 1, 1, 0, 0, 0, 0, 0, 0)};
    tbl[10] = '{k:90,  exp:mk(0, 1, 0, 0, 0, 0, 1, 0, 0)};
    tbl[11] = '{k:98,  exp:mk(0, 1, 0, 0, 0, 0, 0, 0, 0)};
    tbl[12] = '{k:108, exp:mk(0, 1, 1, 0, 0, 0, 1, 0, 0)};
    tbl[13] = '{k:126, exp:mk(0, 1, 1, 1, 0, 0, 1, 1, 1)};
    tbl[14] = '{k:127, exp:mk(1, 1, 1, 1, 0, 0, 0, 0, 1)};

    xres = W'(5); yres = W'(4); clk_div = DIV_W'(2); reset = 1'b0;
    @(negedge clock);
    repeat (3) begin
      tick();
      check("reset_state", dut_obs(), rst_exp);
    end
    reset = 1'b1;

    k = 0;
    for (int i = 0; i < 15; i++) begin
      while (k < tbl[i].k) begin tick(); k++; end
      check($sformatf("table_k%0d", tbl[i].k), dut_obs(), tbl[i].exp);
    end

    // Mid-frame xres change stays invisible until the next frame.
    wait_pos(2, 1, 300, "reach_h2_v1");
    xres = W'(8);
    wait_for(1'b0, 100, "ls_before_change");
    measure_line("old_line_period", 18);
    wait_for(1'b1, 300, "fs_after_xres");
    cnt = 0; n = 0;
    do begin
      if (de) cnt++;
      tick(); n++;
    end while (!line_start && n < 100);
    check_int("new_line_period", n, 24);
    check_int("new_de_width", cnt, 16);

    // Divider 0 and xres 0: pixel every clock, htotal 5.
    clk_div = '0; xres = '0;
    wait_for(1'b1, 400, "fs_div0");
    cnt = 0;
    for (int i = 0; i < 6; i++) begin
      if (pixel_ce) cnt++;
      tick();
    end
    check_int("pce_every_clock", cnt, 6);
    wait_for(1'b0, 50, "ls_div0");
    measure_line("div0_line_period", 5);
    wait_pos(2, 3, 100, "reach_h2_v3");
    reset = 1'b0;
    tick();
    check("mid_frame_reset", dut_obs(), rst_exp);
    xres = W'(5); yres = W'(4); clk_div = DIV_W'(2);
    tick();
    reset = 1'b1;
    tick();
    check("post_reset_strobes", dut_obs(), mk(1, 1, 1, 1, 0, 0, 1, 1, 0));

`ifdef CRT_FRAME_COUNT_EN
    for (int i = 1; i <= 4; i++) begin
      tick();
      wait_for(1'b1, 300, "fc_frame");
      check_int("frame_count", int'(frame_count), i % 4);
    end
`endif

    // Randomized inputs and occasional resets against the model.
    for (int i = 0; i < 4000; i++) begin
      if ($urandom_range(0, 29) == 0) xres = W'($urandom_range(0, 12));
      if ($urandom_range(0, 29) == 0) yres = W'($urandom_range(0, 8));
      if ($urandom_range(0, 29) == 0) clk_div = DIV_W'($urandom_range(0, 3));
      if (!reset) reset = 1'b1;
      else if ($urandom_range(0, 599) == 0) reset = 1'b0;
      tick();
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
